zap_irq_conditioner: RTL and testbench
======================================

# zap_irq_conditioner

Per-line interrupt conditioner that sits directly downstream of the dual-rank synchronizer on each external interrupt line. It debounces the synchronized inputs and qualifies them as level-sensitive or rising-edge-latched. It also holds a pending bit per line until software acknowledges it, and drives a single combined interrupt request to the core.

## Interface
Parameters:
- WIDTH, 2, number of interrupt lines.
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a new level; legal range 1..255.

Ports:
- i_clk  in  1  sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_sync  in  WIDTH  synchronized interrupt lines from the dual-rank synchronizer; already in the i_clk domain.
- i_edge_mode  in  WIDTH  per line: 1 = rising-edge latched, 0 = level; quasi-static.
- i_enable  in  WIDTH  per-line mask for o_irq; does not affect pending state.
- i_ack  in  WIDTH  per-line single-cycle clear of pending; edge mode only.
- o_filtered  out  WIDTH  debounced level per line, registered.
- o_pending  out  WIDTH  pending bits, registered.
- o_irq  out  1  combinational OR of (o_pending & i_enable).

## Operation
- Each line has an independent 4-state FSM and a counter of width $clog2(DEBOUNCE_CYCLES+1).
- States:
  - LOW: filtered = 0.
  - QUAL_HI: candidate rise.
  - HIGH: filtered = 1.
  - QUAL_LO: candidate fall.
- LOW, i_sync=1: go to QUAL_HI with cnt=1. If DEBOUNCE_CYCLES==1, go directly to HIGH.
- QUAL_HI, i_sync=1: cnt++. When the incoming sample makes the count equal DEBOUNCE_CYCLES, go to HIGH and set cnt=0.
- QUAL_HI, i_sync=0: return to LOW with cnt=0. A glitch leaves no trace.
- HIGH, QUAL_LO: mirror image of LOW, QUAL_HI.
- o_filtered = 1 in HIGH and QUAL_LO, 0 otherwise. It is registered alongside the state.
- Level mode: o_pending[i] = o_filtered[i]. i_ack is ignored.
- Edge mode: o_pending[i] is set on the QUAL_HI→HIGH transition, or LOW→HIGH when DEBOUNCE_CYCLES==1. It is cleared by i_ack[i]=1.
- Set and ack in the same cycle: set wins, and pending stays 1.
- Ack with nothing pending: no effect.
- Switching i_edge_mode at runtime takes effect next cycle. Edge-mode pending starts from its current value; the bench does not rely on this.

## Timing
- Reset (async assert, sync-released by the system): all FSMs go to LOW with cnt=0. o_filtered=0, o_pending=0, o_irq=0.
- Reset asserted mid-qualification discards the partial count.
- Latency: i_sync rises before edge k and stays high. Then o_filtered and o_pending (edge mode) are 1 after edge k+DEBOUNCE_CYCLES-1. o_irq follows in the same cycle if enabled.
- A pulse of DEBOUNCE_CYCLES-1 samples is rejected.
- Falling latency is symmetric.
- i_ack sampled at edge m clears pending after edge m.
- i_enable changes reach o_irq combinationally, with no state effect.
- Counter never exceeds DEBOUNCE_CYCLES and never wraps.

## Structure
- The shared package holds the FSM state enum (LOW, QUAL_HI, HIGH, QUAL_LO), 2 bits.
- A natural sub-module is zap_irq_debounce_line: one line's FSM, counter and pending bit.
- The top level instantiates WIDTH copies in a generate loop and ORs the enabled pending bits.

## Test plan
- Reset: hold i_reset_n=0 with i_sync='1 → o_filtered=0, o_pending=0, o_irq=0. Release, then drive i_sync=1 for 4 cycles (D=4) → o_filtered=1 after the 4th edge.
- Glitch rejection, D=4, edge mode: drive i_sync[0]=1 for 3 cycles, then 0 → o_pending[0] stays 0 and the FSM is back in LOW.
- Edge latch and ack, D=4: drive i_sync[0] high for 4+ cycles with i_enable[0]=1 → o_pending[0]=1 and o_irq=1. Pulse i_ack[0] while the line is still high → pending 0, with no re-set until the next filtered rise.
- Simultaneous set and ack: pulse i_ack[1] on the same edge as the qualifying 4th sample → o_pending[1]=1.
- Level mode with mask: drive i_sync[1]=1 for 4 cycles → o_pending[1]=1. Set i_enable[1]=0 → o_irq=0 the same cycle while pending stays 1. Drive the line low for 4 cycles → pending=0. i_ack is ignored throughout.
- D=1 plus mid-qualification reset: with D=1, o_filtered follows i_sync one edge later. With D=4, assert i_reset_n low after 2 high samples and then release → 4 fresh samples are needed before filtered rises.

Source files
------------

// File: rtl/zap_irq_conditioner_pkg.sv
// Shared definitions for the interrupt conditioner: debounce FSM encoding and helpers.
package zap_irq_conditioner_pkg;

   typedef logic [1:0] irq_state_t;

   localparam irq_state_t ST_LOW     = 2'd0;
   localparam irq_state_t ST_QUAL_HI = 2'd1;
   localparam irq_state_t ST_HIGH    = 2'd2;
   localparam irq_state_t ST_QUAL_LO = 2'd3;

   // The filtered level is high while settled high or while a fall is still unproven.
   function automatic logic state_is_high(input irq_state_t s);
      return (s == ST_HIGH) || (s == ST_QUAL_LO);
   endfunction

endpackage

// File: rtl/zap_irq_conditioner_if.sv
// Per-line interrupt bus between software-facing control and the conditioner.
interface zap_irq_conditioner_if #(
   parameter int unsigned WIDTH = 2
);
   logic [WIDTH-1:0] i_sync;
   logic [WIDTH-1:0] i_edge_mode;
   logic [WIDTH-1:0] i_enable;
   logic [WIDTH-1:0] i_ack;
   logic [WIDTH-1:0] o_filtered;
   logic [WIDTH-1:0] o_pending;
   logic             o_irq;

   modport slave (
      input  i_sync, i_edge_mode, i_enable, i_ack,
      output o_filtered, o_pending, o_irq
   );

   modport master (
      output i_sync, i_edge_mode, i_enable, i_ack,
      input  o_filtered, o_pending, o_irq
   );
endinterface

// File: rtl/zap_irq_debounce_line.sv
// One interrupt line: debounce FSM with saturating qualification counter and pending bit.
module zap_irq_debounce_line #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_sync,
   input  logic i_edge_mode,
   input  logic i_ack,
   output logic o_filtered,
   output logic o_pending
);
   import zap_irq_conditioner_pkg::*;

   localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
   localparam logic       SINGLE    = (DEBOUNCE_CYCLES == 1);

   irq_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] cnt_inc;
   logic          rise;

   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         filt_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state: a level is accepted only after DEBOUNCE_CYCLES identical samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (i_sync) begin
               if (SINGLE) begin
                  state_d = ST_HIGH;
                  rise    = 1'b1;
               end else begin
                  state_d = ST_QUAL_HI;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_QUAL_HI: begin
            if (!i_sync) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_DONE) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               rise    = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_HIGH: begin
            if (!i_sync) begin
               if (SINGLE) begin
                  state_d = ST_LOW;
               end else begin
                  state_d = ST_QUAL_LO;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_QUAL_LO: begin
            if (i_sync) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_DONE) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Edge mode latches on a qualified rise (which beats a same-cycle ack); level mode tracks the filter.
   always_comb begin
      filt_d = state_is_high(state_d);
      pend_d = pend_q;
      if (i_edge_mode) begin
         if (rise) begin
            pend_d = 1'b1;
         end else if (i_ack) begin
            pend_d = 1'b0;
         end
      end else begin
         pend_d = filt_d;
      end
   end

   assign o_filtered = filt_q;
   assign o_pending  = pend_q;

endmodule

// File: rtl/zap_irq_conditioner.sv
// Interrupt conditioner top: WIDTH independent debounce lines and a masked combined request.
module zap_irq_conditioner #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   zap_irq_conditioner_if.slave  bus
);
   import zap_irq_conditioner_pkg::*;

   logic [WIDTH-1:0] filtered_w;
   logic [WIDTH-1:0] pending_w;

   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_line
      zap_irq_debounce_line #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_line (
         .i_clk       (i_clk),
         .i_reset_n   (i_reset_n),
         .i_sync      (bus.i_sync[gi]),
         .i_edge_mode (bus.i_edge_mode[gi]),
         .i_ack       (bus.i_ack[gi]),
         .o_filtered  (filtered_w[gi]),
         .o_pending   (pending_w[gi])
      );
   end

   assign bus.o_filtered = filtered_w;
   assign bus.o_pending  = pending_w;
   // Enable masks only the request; pending state is untouched.
   assign bus.o_irq      = |(pending_w & bus.i_enable);

endmodule

// File: tb/tb_zap_irq_conditioner.sv
// Directed bench: a DEBOUNCE_CYCLES=4 instance and a DEBOUNCE_CYCLES=1 instance.
module tb_zap_irq_conditioner;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   zap_irq_conditioner_if #(.WIDTH(2)) bus4 ();
   zap_irq_conditioner_if #(.WIDTH(2)) bus1 ();

   zap_irq_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut4 (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus4)
   );

   zap_irq_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) dut1 (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus1)
   );

   task automatic chk_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk4(input string tag, input logic [1:0] filt, input logic [1:0] pend, input logic irq);
      chk_eq({tag, ".filt"}, 8'(bus4.o_filtered), 8'(filt));
      chk_eq({tag, ".pend"}, 8'(bus4.o_pending), 8'(pend));
      chk_eq({tag, ".irq"},  8'(bus4.o_irq), 8'(irq));
   endtask

   task automatic chk1(input string tag, input logic [1:0] filt, input logic [1:0] pend, input logic irq);
      chk_eq({tag, ".filt"}, 8'(bus1.o_filtered), 8'(filt));
      chk_eq({tag, ".pend"}, 8'(bus1.o_pending), 8'(pend));
      chk_eq({tag, ".irq"},  8'(bus1.o_irq), 8'(irq));
   endtask

   initial begin
      bus4.i_sync = 2'b11; bus4.i_edge_mode = 2'b01; bus4.i_enable = 2'b11; bus4.i_ack = 2'b00;
      bus1.i_sync = 2'b11; bus1.i_edge_mode = 2'b01; bus1.i_enable = 2'b11; bus1.i_ack = 2'b00;

      // Reset held with lines high
      step(2);
      chk4("rst4", 2'b00, 2'b00, 1'b0);
      chk1("rst1", 2'b00, 2'b00, 1'b0);
      bus4.i_enable = 2'b00;
      bus1.i_sync   = 2'b00;
      rst_n = 1'b1;

      // Rise latency: filtered after the 4th sample
      step(3);
      chk4("rise3", 2'b00, 2'b00, 1'b0);
      step(1);
      chk4("rise4", 2'b11, 2'b11, 1'b0);
      bus4.i_enable = 2'b01;
      #1;
      chk_eq("en_irq", 8'(bus4.o_irq), 8'h01);

      // Ack edge-mode line 0 while still high: no re-set
      bus4.i_ack = 2'b01;
      step(1);
      bus4.i_ack = 2'b00;
      chk4("ack0", 2'b11, 2'b10, 1'b0);
      step(3);
      chk4("noreset", 2'b11, 2'b10, 1'b0);

      // Fall latency
      bus4.i_sync = 2'b00;
      step(3);
      chk4("fall3", 2'b11, 2'b10, 1'b0);
      step(1);
      chk4("fall4", 2'b00, 2'b00, 1'b0);

      // Glitch of 3 samples rejected; fresh count afterwards
      bus4.i_sync = 2'b01;
      step(3);
      bus4.i_sync = 2'b00;
      step(1);
      chk4("glitch", 2'b00, 2'b00, 1'b0);
      bus4.i_sync = 2'b01;
      step(3);
      chk4("refill3", 2'b00, 2'b00, 1'b0);
      step(1);
      chk4("refill4", 2'b01, 2'b01, 1'b1);
      bus4.i_ack = 2'b01;
      step(1);
      bus4.i_ack = 2'b00;
      chk4("ack0b", 2'b01, 2'b00, 1'b0);
      bus4.i_sync = 2'b00;
      step(4);
      chk4("low0", 2'b00, 2'b00, 1'b0);

      // Ack on the qualifying edge: set wins
      bus4.i_edge_mode = 2'b11;
      bus4.i_sync = 2'b10;
      step(3);
      bus4.i_ack = 2'b10;
      step(1);
      bus4.i_ack = 2'b00;
      chk4("setack", 2'b10, 2'b10, 1'b0);
      bus4.i_sync = 2'b00;
      step(4);
      chk4("edgehold", 2'b00, 2'b10, 1'b0);
      bus4.i_ack = 2'b10;
      step(1);
      bus4.i_ack = 2'b00;
      chk4("ack1", 2'b00, 2'b00, 1'b0);
      bus4.i_ack = 2'b01;
      step(1);
      bus4.i_ack = 2'b00;
      chk4("ackidle", 2'b00, 2'b00, 1'b0);

      // Level mode with mask, ack held throughout
      bus4.i_edge_mode = 2'b00;
      bus4.i_ack = 2'b11;
      bus4.i_sync = 2'b10;
      step(3);
      chk4("lvl3", 2'b00, 2'b00, 1'b0);
      step(1);
      chk4("lvl4", 2'b10, 2'b10, 1'b0);
      bus4.i_enable = 2'b11;
      #1;
      chk_eq("lvl_en", 8'(bus4.o_irq), 8'h01);
      bus4.i_enable = 2'b01;
      #1;
      chk4("lvl_mask", 2'b10, 2'b10, 1'b0);
      bus4.i_sync = 2'b00;
      step(3);
      chk4("lvlfall3", 2'b10, 2'b10, 1'b0);
      step(1);
      chk4("lvlfall4", 2'b00, 2'b00, 1'b0);
      bus4.i_ack = 2'b00;

      // Single-sample debounce follows one edge later
      bus1.i_enable = 2'b11;
      bus1.i_sync = 2'b01;
      step(1);
      chk1("d1rise", 2'b01, 2'b01, 1'b1);
      bus1.i_sync = 2'b00;
      step(1);
      chk1("d1fall", 2'b00, 2'b01, 1'b1);
      bus1.i_sync = 2'b10;
      step(1);
      chk1("d1lvl", 2'b10, 2'b11, 1'b1);
      bus1.i_ack = 2'b01;
      step(1);
      bus1.i_ack = 2'b00;
      chk1("d1ack", 2'b10, 2'b10, 1'b1);
      bus1.i_sync = 2'b00;
      step(1);
      chk1("d1low", 2'b00, 2'b00, 1'b0);

      // Reset mid-qualification discards the partial count
      bus4.i_edge_mode = 2'b01;
      bus4.i_sync = 2'b01;
      step(2);
      rst_n = 1'b0;
      #1;
      chk4("midrst", 2'b00, 2'b00, 1'b0);
      step(1);
      rst_n = 1'b1;
      step(3);
      chk4("post3", 2'b00, 2'b00, 1'b0);
      step(1);
      chk4("post4", 2'b01, 2'b01, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
